clock_out_multi_controller: RTL and testbench
=============================================

Name: clock_out_multi_controller

Overview:
- Multi-channel divided-clock generator for the pulse controller's external clock outputs.
- Each channel has a programmable period and high time (duty).
- Parameter updates are glitch-free: they take effect only at a period boundary, or immediately when the channel is idle.
- A global sync strobe phase-aligns all running channels.

Parameters:
CLOCK_WIDTH, 8, width of the divider field; channel period P = 2*(div+1) cycles
NCHANNELS, 4, number of independent clock outputs (1..16)

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
wr_en  input  1  write strobe, sampled on the rising edge of clock
wr_chn  input  4  target channel of the write
wr_div  input  CLOCK_WIDTH  divider value; all-ones = disable channel
wr_high  input  CLOCK_WIDTH+1  high time in cycles; 0 = 50% duty (div+1)
sync  input  1  one-cycle strobe: restart all enabled channels at phase 0
out  output  NCHANNELS  divided clock outputs (registered)
pending  output  NCHANNELS  per channel: a written update is not yet applied

Behaviour:
- Per-channel state:
  - active div/high registers;
  - pending div/high registers plus pending flag;
  - counter of CLOCK_WIDTH+1 bits;
  - out bit.
- Reset (async):
  - out=0, pending=0, counters=0.
  - Active and pending div = all-ones (disabled), high = 0.
- Effective high H:
  - H = div+1 if high==0.
  - H = P-1 if high>=P.
  - Otherwise H = high.
  - H is computed from the active registers.
- Idle channel (active div all-ones):
  - counter held 0, out held 0.
  - A write to an idle channel applies on that same edge: active regs loaded, counter=0, out=(H>0)=1.
  - pending stays 0.
  - Writing disable to an idle channel leaves it idle.
- Running channel:
  - Counter counts 0..P-1 and wraps to 0.
  - out is registered: out <= (counter_next < H_next).
  - Result: out is high for H cycles from phase 0, then low for P-H cycles.
- Write to a running channel:
  - Loads the pending regs and sets pending=1 on the next edge.
  - A later write before the boundary overwrites pending (last write wins).
- Period boundary (counter==P-1):
  - If pending: load active from pending, clear pending, counter_next=0, out from the new H.
  - If the new div is all-ones: channel goes idle, out=0 at that edge.
- sync:
  - Every running channel, and every channel with pending set, gets counter_next=0.
  - Any pending is applied on that edge; out_next=1.
  - Idle channels without pending are unaffected.
- Simultaneous write and sync to the same channel: the written value is applied immediately by the sync (write wins over old pending).
- Simultaneous write and boundary on the same channel: the written value is applied at that boundary.
- wr_chn >= NCHANNELS: write ignored, no state change.
- Reset mid-operation: all outputs drop to 0 asynchronously. The first write after release behaves as a write to an idle channel.
- Legacy compatibility: high=0 gives 50% duty, period 2*(div+1), identical to the single-channel divider.
- Widths:
  - Counter and P comparisons use CLOCK_WIDTH+1 bits; P-1 = 2*div+1 never overflows since div < 2^CLOCK_WIDTH-1.
  - No arithmetic wraps except the counter wrap at P-1.

Test Plan:
1. Reset; write ch0 div=0 high=0 → out[0] = 1,0,1,0… starting the edge of the write; other outs stay 0; pending=0.
2. ch1 div=2 high=1 running → P=6: out[1] = 1 high, 5 low, repeating. Mid-period write div=1 high=0 → pending[1]=1 until counter==5. Next period P=4 with 2 high/2 low, no runt pulse.
3. ch0 div=3 and ch2 div=1, free-running, out of phase; pulse sync → both outs high on the next edge with counters 0. ch3 idle stays 0.
4. Running ch1 written div=all-ones → continues to counter==P-1, then out[1]=0 permanently, pending cleared. wr_chn=7 (NCHANNELS=4) → no change on any output.
5. high=200 with div=2 → clamped to H=5 (5 high, 1 low). Write and sync in the same cycle → new setting starts at phase 0 on that edge.
6. Assert reset asynchronously mid-high on all channels → out=0 and pending=0 immediately. After release, outputs stay 0 until written.

Source files
------------

// File: rtl/clock_out_multi_controller.sv
// Multi-channel divided-clock generator with glitch-free period/duty updates.
// Updates apply at a period boundary, on sync, or at once on an idle channel.
module clock_out_multi_controller #(
  parameter int CLOCK_WIDTH = 8,
  parameter int NCHANNELS   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_chn,
  input  logic [CLOCK_WIDTH-1:0] wr_div,
  input  logic [CLOCK_WIDTH:0]   wr_high,
  input  logic                   sync,
  output logic [NCHANNELS-1:0]   out,
  output logic [NCHANNELS-1:0]   pending
);

  localparam int CW = CLOCK_WIDTH;
  localparam logic [CW-1:0] DIV_OFF = '1;
  localparam logic [CW:0]   ONE     = (CW+1)'(1);

  // Effective high time; the last phase of a period is always {div, 1'b1}.
  function automatic logic [CW:0] eff_high(input logic [CW-1:0] div,
                                           input logic [CW:0]   high);
    logic [CW:0] last_phase;
    last_phase = {div, 1'b1};
    if (high == '0)
      eff_high = {1'b0, div} + ONE;
    else if (high > last_phase)
      eff_high = last_phase;
    else
      eff_high = high;
  endfunction

  for (genvar g = 0; g < NCHANNELS; g++) begin : g_chn
    logic [CW-1:0] act_div;
    logic [CW:0]   act_high;
    logic [CW-1:0] pnd_div;
    logic [CW:0]   pnd_high;
    logic          pnd_q;
    logic [CW:0]   cnt;
    logic          out_q;

    logic          hit;
    logic          idle;
    logic          at_end;
    logic          apply;
    logic [CW-1:0] new_div;
    logic [CW:0]   new_high;
    logic [CW:0]   cnt_inc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      hit      = wr_en && (wr_chn == 4'(g));
      idle     = (act_div == DIV_OFF);
      at_end   = !idle && (cnt == {act_div, 1'b1});
      cnt_inc  = cnt + ONE;
      new_div  = act_div;
      new_high = act_high;
      if (hit) begin
        new_div  = wr_div;
        new_high = wr_high;
      end else if (pnd_q) begin
        new_div  = pnd_div;
        new_high = pnd_high;
      end
      // A fresh write beats older pending values whenever an update is taken.
      apply = (idle && hit)
           || (sync && (!idle || pnd_q))
           || (at_end && (pnd_q || hit));
    end

    // NOTE: sequential state uses non-blocking assignments so every channel
    // sees the pre-edge values of its own registers.
    // NOTE: the parameter registers are reset too, so a channel is provably
    // idle (disabled) after reset rather than running on garbage.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        act_div  <= DIV_OFF;
        act_high <= '0;
        pnd_div  <= DIV_OFF;
        pnd_high <= '0;
        pnd_q    <= 1'b0;
        cnt      <= '0;
        out_q    <= 1'b0;
      end else if (apply) begin
        act_div  <= new_div;
        act_high <= new_high;
        pnd_q    <= 1'b0;
        cnt      <= '0;
        // Effective high time is never zero, so phase 0 is high unless disabled.
        out_q    <= (new_div != DIV_OFF);
      end else if (hit) begin
        pnd_div  <= wr_div;
        pnd_high <= wr_high;
        pnd_q    <= 1'b1;
        cnt      <= cnt_inc;
        out_q    <= (cnt_inc < eff_high(act_div, act_high));
      end else if (idle) begin
        cnt   <= '0;
        out_q <= 1'b0;
      end else if (at_end) begin
        cnt   <= '0;
        out_q <= 1'b1;
      end else begin
        cnt   <= cnt_inc;
        out_q <= (cnt_inc < eff_high(act_div, act_high));
      end
    end

    assign out[g]     = out_q;
    assign pending[g] = pnd_q;
  end

endmodule

// File: tb/tb_clock_out_multi_controller.sv
// Randomized self-checking bench for clock_out_multi_controller using a
// phase-based reference model of each channel.
module tb_clock_out_multi_controller;

  localparam int CW  = 8;
  localparam int NCH = 4;
  localparam int OFF = (1 << CW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 1'b0;
  logic [3:0]     wr_chn = '0;
  logic [CW-1:0]  wr_div = '0;
  logic [CW:0]    wr_high = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] out;
  logic [NCH-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Model: active div/high, phase within the period, pending update.
  int m_div[NCH], m_high[NCH], m_ph[NCH];
  int m_pv[NCH], m_pdiv[NCH], m_phigh[NCH];

  clock_out_multi_controller #(.CLOCK_WIDTH(CW), .NCHANNELS(NCH)) dut (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_chn (wr_chn),
    .wr_div (wr_div),
    .wr_high(wr_high),
    .sync   (sync),
    .out    (out),
    .pending(pending)
  );

  always #5 clock = ~clock;

  function automatic int m_h(input int c);
    int p;
    p = 2 * (m_div[c] + 1);
    if (m_high[c] == 0) return m_div[c] + 1;
    if (m_high[c] >= p) return p - 1;
    return m_high[c];
  endfunction

  function automatic logic [NCH-1:0] m_out();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++)
      r[c] = (m_div[c] != OFF) && (m_ph[c] < m_h(c));
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_pend();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_pv[c] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = OFF; m_high[c] = 0; m_ph[c] = 0;
      m_pv[c] = 0; m_pdiv[c] = OFF; m_phigh[c] = 0;
    end
  endtask

  task automatic model_step(input bit wen, input int chn, input int div,
                            input int high, input bit s);
    for (int c = 0; c < NCH; c++) begin
      bit hit, idle, restart;
      hit  = wen && (chn == c);
      idle = (m_div[c] == OFF);
      if (idle) restart = hit || (s && m_pv[c] != 0);
      else      restart = s || (m_ph[c] == 2 * (m_div[c] + 1) - 1);
      if (restart) begin
        if (hit) begin
          m_div[c] = div; m_high[c] = high;
        end else if (m_pv[c] != 0) begin
          m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c];
        end
        m_pv[c] = 0;
        m_ph[c] = 0;
      end else if (!idle) begin
        if (hit) begin
          m_pv[c] = 1; m_pdiv[c] = div; m_phigh[c] = high;
        end
        m_ph[c] = m_ph[c] + 1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the clock and the model together.
  task automatic tick(input bit wen, input int chn, input int div,
                      input int high, input bit s);
    wr_en = wen; wr_chn = chn[3:0]; wr_div = div[CW-1:0];
    wr_high = high[CW:0]; sync = s;
    @(posedge clock);
    model_step(wen, chn, div, high, s);
    #1;
    wr_en = 1'b0; sync = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12 reset = 1'b0;
    #1;
    checks++;
    if (out !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL reset: out=%b pending=%b expected 0000/0000", out, pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0);
      checks++;
      if (out !== '0 || pending !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: out=%b pending=%b expected 0000/0000", i, out, pending);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] seen;
    tick(1, 0, 0, 0, 0);
    seen[0] = out[0];
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL basic cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
      seen[i] = out[0];
    end
    checks++;
    if (seen !== 8'b0101_0101) begin
      errors++;
      $display("FAIL basic_pattern: out0 seq=%b expected 01010101 (lsb first)", seen);
    end
  endtask

  task automatic test_update();
    tick(1, 1, 2, 1, 0);
    for (int i = 0; i < 2; i++) tick(0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    checks++;
    if (pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL update_pending: pending1=%b expected 1", pending[1]);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL update cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_sync();
    tick(1, 0, 3, 0, 0);
    tick(1, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    checks++;
    if (out[0] !== 1'b1 || out[2] !== 1'b1 || out[3] !== 1'b0) begin
      errors++;
      $display("FAIL sync_align: out=%b expected ch0=1 ch2=1 ch3=0", out);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL sync cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_disable();
    tick(1, 1, OFF, 0, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL disable cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
    checks++;
    if (out[1] !== 1'b0 || pending[1] !== 1'b0) begin
      errors++;
      $display("FAIL disable_final: out1=%b pending1=%b expected 0/0", out[1], pending[1]);
    end
    tick(1, 7, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL bad_chn cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_clamp_sync();
    logic [5:0] seen;
    tick(1, 3, 2, 200, 1);
    for (int i = 0; i < 6; i++) begin
      seen[i] = out[3];
      tick(0, 0, 0, 0, 0);
    end
    checks++;
    if (seen !== 6'b01_1111) begin
      errors++;
      $display("FAIL clamp_pattern: out3 seq=%b expected 011111 (lsb first)", seen);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    tick(1, 0, 1, 3, 1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL write_sync cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    int highs[6] = '{0, 1, 3, 7, 200, 511};
    for (int i = 0; i < 3000; i++) begin
      bit wen, s;
      int chn, div, high;
      wen  = ($urandom_range(0, 5) == 0);
      s    = ($urandom_range(0, 24) == 0);
      chn  = $urandom_range(0, 5);
      div  = ($urandom_range(0, 7) == 0) ? OFF : $urandom_range(0, 4);
      high = ($urandom_range(0, 1) == 0) ? highs[$urandom_range(0, 5)]
                                         : $urandom_range(0, 12);
      tick(wen, chn, div, high, s);
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL random cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < NCH; c++) tick(1, c, 3, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(1, 1, 2, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL async_reset: out=%b pending=%b expected 0000/0000", out, pending);
    end
    @(posedge clock);
    #3 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 0);
      checks++;
      if (out !== '0 || pending !== '0) begin
        errors++;
        $display("FAIL post_reset cyc %0d: out=%b pending=%b expected 0000/0000", i, out, pending);
      end
    end
    tick(1, 2, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out !== m_out() || pending !== m_pend()) begin
        errors++;
        $display("FAIL reset_rewrite cyc %0d: out=%b pending=%b expected %b/%b", i, out, pending, m_out(), m_pend());
      end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_update();
    test_sync();
    test_disable();
    test_clamp_sync();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
